cp_insert: RTL and testbench

Cyclic-prefix insertion stage that sits directly downstream of the IFFT in the OFDM transmit chain. It captures each 64-sample time-domain symbol from the IFFT into a ping-pong buffer. It then emits the last CP_LEN samples followed by all 64 samples as one contiguous burst of 64+CP_LEN samples. The per-symbol block exponent travels with the burst.

---
 rtl/cp_insert.sv | 139 +++++++++++++
 tb/tb_cp_insert.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_insert.sv
// Cyclic-prefix insertion: captures 64-sample IFFT symbols into a ping-pong buffer
// and replays each as CP_LEN prefix samples followed by the full symbol.
module cp_insert #(
  parameter int WIDTH  = 16,
  parameter int CP_LEN = 16
) (
  input  logic             cp_clk,
  input  logic             cp_rst,
  input  logic             din_valid,
  input  logic [5:0]       din_index,
  input  logic [5:0]       din_exp,
  input  logic [WIDTH-1:0] cp_real_din,
  input  logic [WIDTH-1:0] cp_imag_din,
  output logic             dout_valid,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic [6:0]       dout_index,
  output logic [5:0]       dout_exp,
  output logic [WIDTH-1:0] cp_real_dout,
  output logic [WIDTH-1:0] cp_imag_dout,
  output logic             ovf
);

  localparam logic [5:0] CP_START  = 6'(64 - CP_LEN);
  localparam logic [6:0] CP_START7 = 7'(64 - CP_LEN);
  localparam logic [6:0] CP_LEN7   = 7'(CP_LEN);

  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

  logic [2*WIDTH-1:0] mem [0:127];
  logic [1:0]         full;
  logic [1:0][5:0]    bank_exp;
  logic               wr_bank;
  logic               rd_bank;
  logic               drop;
  logic               in_sym;
  state_t             state;
  logic [5:0]         rd_addr;

  logic burst_end;
  logic bank_free;
  logic sym_start;
  logic accept;
  logic sym_done;

  // A bank being released by the reader this cycle counts as free for a new symbol.
  assign burst_end = (state == BODY) && (rd_addr == 6'd63);
  assign bank_free = !full[wr_bank] || (burst_end && (rd_bank == wr_bank));
  assign sym_start = din_valid && (din_index == 6'd0);
  assign accept    = din_valid && (sym_start ? bank_free : (in_sym && !drop));
  assign sym_done  = accept && (din_index == 6'd63);

  // NOTE: the sample storage carries no reset; only the full flags decide what is valid.
  always_ff @(posedge cp_clk) begin
    if (accept) mem[{wr_bank, din_index}] <= {cp_real_din, cp_imag_din};
  end

  always_ff @(posedge cp_clk or posedge cp_rst) begin
    if (cp_rst) begin
      full         <= '0;
      bank_exp     <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      drop         <= 1'b0;
      in_sym       <= 1'b0;
      state        <= IDLE;
      rd_addr      <= '0;
      ovf          <= 1'b0;
      dout_valid   <= 1'b0;
      dout_sop     <= 1'b0;
      dout_eop     <= 1'b0;
      dout_index   <= '0;
      dout_exp     <= '0;
      cp_real_dout <= '0;
      cp_imag_dout <= '0;
    end else begin
      // Write side: the admit/drop decision is taken once per symbol at index 0.
      ovf <= sym_start && !bank_free;
      if (sym_start) begin
        drop   <= !bank_free;
        in_sym <= 1'b1;
      end else if (din_valid && (din_index == 6'd63)) begin
        in_sym <= 1'b0;
      end

      if (burst_end) full[rd_bank] <= 1'b0;
      if (sym_done) begin
        full[wr_bank]     <= 1'b1;
        bank_exp[wr_bank] <= din_exp;
        wr_bank           <= ~wr_bank;
      end

      // NOTE: every register here uses <= so all reads see pre-edge values.
      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            state   <= CP;
            rd_addr <= CP_START;
          end
        end
        CP: begin
          rd_addr <= rd_addr + 6'd1;
          if (rd_addr == 6'd63) state <= BODY;
        end
        BODY: begin
          rd_addr <= rd_addr + 6'd1;
          if (rd_addr == 6'd63) begin
            rd_bank <= ~rd_bank;
            if (full[~rd_bank]) begin
              state   <= CP;
              rd_addr <= CP_START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Output stage registers the bank read one cycle after the address is issued.
      dout_valid <= (state != IDLE);
      dout_sop   <= (state == CP) && (rd_addr == CP_START);
      dout_eop   <= burst_end;
      case (state)
        CP:      dout_index <= {1'b0, rd_addr} - CP_START7;
        BODY:    dout_index <= {1'b0, rd_addr} + CP_LEN7;
        default: dout_index <= '0;
      endcase
      if ((state == CP) && (rd_addr == CP_START)) dout_exp <= bank_exp[rd_bank];
      if (state != IDLE) begin
        {cp_real_dout, cp_imag_dout} <= mem[{rd_bank, rd_addr}];
      end else begin
        cp_real_dout <= '0;
        cp_imag_dout <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cp_insert.sv
// Directed bench for cp_insert: two instances (CP_LEN=16 and CP_LEN=8) share stimulus,
// a negedge monitor records every output sample, and each scenario task checks the record.
module tb_cp_insert;

  logic        cp_clk    = 1'b0;
  logic        cp_rst    = 1'b1;
  logic        din_valid = 1'b0;
  logic [5:0]  din_index = '0;
  logic [5:0]  din_exp   = '0;
  logic [15:0] real_in   = '0;
  logic [15:0] imag_in   = '0;

  logic        v16, sop16, eop16, ovf16;
  logic [6:0]  idx16;
  logic [5:0]  ex16;
  logic [15:0] re16, im16;
  logic        v8, sop8, eop8, ovf8;
  logic [6:0]  idx8;
  logic [5:0]  ex8;
  logic [15:0] re8, im8;

  cp_insert #(.WIDTH(16), .CP_LEN(16)) u16 (
    .cp_clk(cp_clk), .cp_rst(cp_rst), .din_valid(din_valid), .din_index(din_index),
    .din_exp(din_exp), .cp_real_din(real_in), .cp_imag_din(imag_in),
    .dout_valid(v16), .dout_sop(sop16), .dout_eop(eop16), .dout_index(idx16),
    .dout_exp(ex16), .cp_real_dout(re16), .cp_imag_dout(im16), .ovf(ovf16));

  cp_insert #(.WIDTH(16), .CP_LEN(8)) u8 (
    .cp_clk(cp_clk), .cp_rst(cp_rst), .din_valid(din_valid), .din_index(din_index),
    .din_exp(din_exp), .cp_real_din(real_in), .cp_imag_din(imag_in),
    .dout_valid(v8), .dout_sop(sop8), .dout_eop(eop8), .dout_index(idx8),
    .dout_exp(ex8), .cp_real_dout(re8), .cp_imag_dout(im8), .ovf(ovf8));

  always #5 cp_clk = ~cp_clk;

  int cyc = 0;
  always @(posedge cp_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] re;
    logic [15:0] im;
    logic [6:0]  idx;
    logic        sop;
    logic        eop;
    logic [5:0]  ex;
  } rec_t;

  rec_t q16[$];
  rec_t q8[$];
  rec_t r16, r8;
  int   ovf_n   = 0;
  int   ovf_cyc = -1;
  int   total   = 0;
  int   bad     = 0;

  always @(negedge cp_clk) begin
    if (v16 === 1'b1) begin
      r16.cyc = cyc; r16.re = re16; r16.im = im16; r16.idx = idx16;
      r16.sop = sop16; r16.eop = eop16; r16.ex = ex16;
      q16.push_back(r16);
    end
    if (v8 === 1'b1) begin
      r8.cyc = cyc; r8.re = re8; r8.im = im8; r8.idx = idx8;
      r8.sop = sop8; r8.eop = eop8; r8.ex = ex8;
      q8.push_back(r8);
    end
    if (ovf16 === 1'b1) begin
      ovf_n   = ovf_n + 1;
      ovf_cyc = cyc;
    end
  end

  // Expected real sample at burst position k: prefix replays addresses 64-cp..63.
  function automatic logic [15:0] exp_re(input int sym, input int k, input int cp);
    int a;
    a = (k < cp) ? (64 - cp + k) : (k - cp);
    return 16'(sym * 256 + a);
  endfunction

  task automatic do_reset();
    cp_rst    = 1'b1;
    din_valid = 1'b0;
    repeat (3) @(posedge cp_clk);
    #1;
    cp_rst = 1'b0;
    q16.delete();
    q8.delete();
    @(posedge cp_clk);
    #1;
  endtask

  task automatic send_symbol(input int sym, input logic [5:0] ex, input bit sparse,
                             output int t0, output int t63);
    t0  = 0;
    t63 = 0;
    for (int i = 0; i < 64; i++) begin
      din_valid = 1'b1;
      din_index = 6'(i);
      din_exp   = ex;
      real_in   = 16'(sym * 256 + i);
      imag_in   = ~real_in + 16'd1;
      @(posedge cp_clk);
      #1;
      if (i == 0)  t0  = cyc;
      if (i == 63) t63 = cyc;
      if (sparse) begin
        din_valid = 1'b0;
        @(posedge cp_clk);
        #1;
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge cp_clk);
    #1;
  endtask

  task automatic test_reset();
    cp_rst = 1'b1;
    repeat (2) @(posedge cp_clk);
    #1;
    total++;
    if ({v16, sop16, eop16, ovf16, idx16, ex16} !== 17'd0 || re16 !== 16'd0 || im16 !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b sop=%b eop=%b ovf=%b idx=%0d exp=%0d re=%h im=%h want all 0",
               v16, sop16, eop16, ovf16, idx16, ex16, re16, im16);
    end
    do_reset();
    idle(20);
    total++;
    if (q16.size() != 0 || ovf_n != 0) begin
      bad++;
      $display("FAIL reset_quiet got samples=%0d ovf=%0d want 0 and 0", q16.size(), ovf_n);
    end
  endtask

  task automatic test_single();
    int t0, t63;
    logic [15:0] er;
    do_reset();
    send_symbol(0, 6'd2, 1'b0, t0, t63);
    idle(100);
    total++;
    if (q16.size() != 80) begin
      bad++;
      $display("FAIL single_len got=%0d want=80", q16.size());
    end
    for (int k = 0; k < 80 && k < q16.size(); k++) begin
      er = exp_re(0, k, 16);
      total++;
      if (q16[k].re !== er || q16[k].im !== (~er + 16'd1) || q16[k].idx !== 7'(k) ||
          q16[k].sop !== (k == 0) || q16[k].eop !== (k == 79) || q16[k].ex !== 6'd2 ||
          q16[k].cyc != t63 + 2 + k) begin
        bad++;
        $display("FAIL single k=%0d got re=%h im=%h idx=%0d sop=%b eop=%b exp=%0d cyc=%0d want re=%h idx=%0d exp=2 cyc=%0d",
                 k, q16[k].re, q16[k].im, q16[k].idx, q16[k].sop, q16[k].eop, q16[k].ex,
                 q16[k].cyc, er, k, t63 + 2 + k);
      end
    end
  endtask

  task automatic test_two_gap();
    int ta0, ta63, tb0, tb63, b, kk;
    logic [15:0] er;
    logic [5:0]  ee;
    do_reset();
    send_symbol(1, 6'd3, 1'b0, ta0, ta63);
    idle(16);
    send_symbol(2, 6'd5, 1'b0, tb0, tb63);
    idle(200);
    total++;
    if (q16.size() != 160) begin
      bad++;
      $display("FAIL two_gap_len got=%0d want=160", q16.size());
    end
    for (int k = 0; k < 160 && k < q16.size(); k++) begin
      b  = k / 80;
      kk = k % 80;
      er = exp_re(1 + b, kk, 16);
      ee = (b == 0) ? 6'd3 : 6'd5;
      total++;
      if (q16[k].re !== er || q16[k].im !== (~er + 16'd1) || q16[k].idx !== 7'(kk) ||
          q16[k].sop !== (kk == 0) || q16[k].eop !== (kk == 79) || q16[k].ex !== ee ||
          q16[k].cyc != ta63 + 2 + k) begin
        bad++;
        $display("FAIL two_gap k=%0d got re=%h idx=%0d sop=%b eop=%b exp=%0d cyc=%0d want re=%h idx=%0d exp=%0d cyc=%0d",
                 k, q16[k].re, q16[k].idx, q16[k].sop, q16[k].eop, q16[k].ex, q16[k].cyc,
                 er, kk, ee, ta63 + 2 + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ta0, ta63, tb0, tb63, tc0, tc63, td0, td63, ovf0, b, kk, st, sym;
    logic [15:0] er;
    logic [5:0]  ee;
    do_reset();
    ovf0 = ovf_n;
    send_symbol(1, 6'd1, 1'b0, ta0, ta63);
    send_symbol(2, 6'd2, 1'b0, tb0, tb63);
    send_symbol(3, 6'd3, 1'b0, tc0, tc63);
    idle(100);
    total++;
    if (ovf_n - ovf0 != 1 || ovf_cyc != tc0) begin
      bad++;
      $display("FAIL overflow_pulse got count=%0d at=%0d want count=1 at=%0d", ovf_n - ovf0, ovf_cyc, tc0);
    end
    send_symbol(4, 6'd4, 1'b0, td0, td63);
    idle(100);
    total++;
    if (q16.size() != 240) begin
      bad++;
      $display("FAIL overflow_len got=%0d want=240", q16.size());
    end
    for (int k = 0; k < 240 && k < q16.size(); k++) begin
      b   = k / 80;
      kk  = k % 80;
      sym = (b == 2) ? 4 : (b + 1);
      st  = (b == 2) ? (td63 + 2 + kk) : (ta63 + 2 + k);
      er  = exp_re(sym, kk, 16);
      ee  = 6'(sym);
      total++;
      if (q16[k].re !== er || q16[k].im !== (~er + 16'd1) || q16[k].idx !== 7'(kk) ||
          q16[k].sop !== (kk == 0) || q16[k].eop !== (kk == 79) || q16[k].ex !== ee ||
          q16[k].cyc != st) begin
        bad++;
        $display("FAIL overflow k=%0d got re=%h idx=%0d sop=%b eop=%b exp=%0d cyc=%0d want re=%h idx=%0d exp=%0d cyc=%0d",
                 k, q16[k].re, q16[k].idx, q16[k].sop, q16[k].eop, q16[k].ex, q16[k].cyc,
                 er, kk, ee, st);
      end
    end
  endtask

  task automatic test_sparse();
    int t0, t63;
    logic [15:0] er;
    do_reset();
    send_symbol(3, 6'd7, 1'b1, t0, t63);
    idle(100);
    total++;
    if (q16.size() != 80) begin
      bad++;
      $display("FAIL sparse_len got=%0d want=80", q16.size());
    end
    for (int k = 0; k < 80 && k < q16.size(); k++) begin
      er = exp_re(3, k, 16);
      total++;
      if (q16[k].re !== er || q16[k].im !== (~er + 16'd1) || q16[k].idx !== 7'(k) ||
          q16[k].sop !== (k == 0) || q16[k].eop !== (k == 79) || q16[k].ex !== 6'd7 ||
          q16[k].cyc != t63 + 2 + k) begin
        bad++;
        $display("FAIL sparse k=%0d got re=%h idx=%0d sop=%b eop=%b exp=%0d cyc=%0d want re=%h idx=%0d exp=7 cyc=%0d",
                 k, q16[k].re, q16[k].idx, q16[k].sop, q16[k].eop, q16[k].ex, q16[k].cyc,
                 er, k, t63 + 2 + k);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0, t63;
    bit reached;
    logic [15:0] er;
    do_reset();
    send_symbol(5, 6'd9, 1'b0, t0, t63);
    reached = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge cp_clk);
      if (q16.size() >= 30) begin
        reached = 1'b1;
        break;
      end
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL reset_mid_wait got samples=%0d want >=30 before timeout", q16.size());
    end
    cp_rst = 1'b1;
    #1;
    total++;
    if ({v16, sop16, eop16, ovf16} !== 4'd0 || idx16 !== 7'd0 || ex16 !== 6'd0) begin
      bad++;
      $display("FAIL reset_mid_flags got v=%b sop=%b eop=%b ovf=%b idx=%0d exp=%0d want all 0",
               v16, sop16, eop16, ovf16, idx16, ex16);
    end
    total++;
    if (re16 !== 16'd0 || im16 !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid_data got re=%h im=%h want 0 0", re16, im16);
    end
    @(posedge cp_clk);
    #1;
    cp_rst = 1'b0;
    q16.delete();
    idle(150);
    total++;
    if (q16.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_residual got samples=%0d want=0", q16.size());
    end
    send_symbol(6, 6'd11, 1'b0, t0, t63);
    idle(100);
    total++;
    if (q16.size() != 80) begin
      bad++;
      $display("FAIL reset_mid_len got=%0d want=80", q16.size());
    end
    for (int k = 0; k < 80 && k < q16.size(); k++) begin
      er = exp_re(6, k, 16);
      total++;
      if (q16[k].re !== er || q16[k].im !== (~er + 16'd1) || q16[k].idx !== 7'(k) ||
          q16[k].sop !== (k == 0) || q16[k].eop !== (k == 79) || q16[k].ex !== 6'd11 ||
          q16[k].cyc != t63 + 2 + k) begin
        bad++;
        $display("FAIL reset_mid_burst k=%0d got re=%h idx=%0d sop=%b eop=%b exp=%0d cyc=%0d want re=%h idx=%0d exp=11 cyc=%0d",
                 k, q16[k].re, q16[k].idx, q16[k].sop, q16[k].eop, q16[k].ex, q16[k].cyc,
                 er, k, t63 + 2 + k);
      end
    end
  endtask

  task automatic test_cp8();
    int t0, t63;
    logic [15:0] er;
    do_reset();
    send_symbol(7, 6'd13, 1'b0, t0, t63);
    idle(100);
    total++;
    if (q8.size() != 72) begin
      bad++;
      $display("FAIL cp8_len got=%0d want=72", q8.size());
    end
    for (int k = 0; k < 72 && k < q8.size(); k++) begin
      er = exp_re(7, k, 8);
      total++;
      if (q8[k].re !== er || q8[k].im !== (~er + 16'd1) || q8[k].idx !== 7'(k) ||
          q8[k].sop !== (k == 0) || q8[k].eop !== (k == 71) || q8[k].ex !== 6'd13 ||
          q8[k].cyc != t63 + 2 + k) begin
        bad++;
        $display("FAIL cp8 k=%0d got re=%h idx=%0d sop=%b eop=%b exp=%0d cyc=%0d want re=%h idx=%0d exp=13 cyc=%0d",
                 k, q8[k].re, q8[k].idx, q8[k].sop, q8[k].eop, q8[k].ex, q8[k].cyc,
                 er, k, t63 + 2 + k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_gap();
    test_back_to_back();
    test_sparse();
    test_reset_mid();
    test_cp8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
